// File: rtl/sfr_arb_pkg.sv
// sfr_arb_pkg: shared types and constants for the SFR arbiter.
//   sfr_arb_state_t    - arbiter FSM state (IDLE / WAIT_RESP)
//   SFR_ARB_ERR_RDATA  - read data returned to a master when its read times out
package sfr_arb_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } sfr_arb_state_t;

  localparam logic [31:0] SFR_ARB_ERR_RDATA = 32'hDEADDEAD;

endpackage

// File: rtl/sfr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   [N]       request vector
//   ptr_i   [PW]      highest-priority index (must be < N)
//   grant_o [PW]      first requesting index at or after ptr_i, wrapping at N
//   valid_o           any request present
module rr_pick #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] grant_o,
  output logic          valid_o
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] rot;
  int             g;

  // Duplicate the vector and shift it down so bit 0 is the pointer slot;
  // the first set bit in the low N bits is the offset from ptr_i.
  assign req2 = {req_i, req_i};
  assign rot  = req2 >> ptr_i;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    g       = 0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && rot[i]) begin
        valid_o = 1'b1;
        g       = int'(ptr_i) + i;
        if (g >= N) g = g - N;
        grant_o = PW'(g);
      end
    end
  end

endmodule

// File: rtl/sfr_arbiter.sv
// sfr_arbiter: shares one SFR slave between MASTER_NUM requesters.
//   Round-robin grant, one outstanding read, read response routed back to
//   its issuer, forced error response after RESP_TIMEOUT cycles of silence.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   m_req_i/m_we_i/m_addr_bi/m_be_bi/m_wdata_bi : per-master request fields
//   m_ack_o  : per-master accept      m_resp_o : per-master read data valid
//   m_rdata_bo : shared read data (valid for master k when m_resp_o[k])
//   s_req_o/s_we_o/s_addr_bo/s_be_bo/s_wdata_bo : slave request
//   s_ack_i/s_resp_i/s_rdata_bi : slave accept / read response
//   timeout_o : pulse when a read is answered by the timeout
module sfr_arbiter
  import sfr_arb_pkg::*;
#(
  parameter int MASTER_NUM   = 2,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [MASTER_NUM-1:0]    m_req_i,
  input  logic [MASTER_NUM-1:0]    m_we_i,
  input  logic [MASTER_NUM*32-1:0] m_addr_bi,
  input  logic [MASTER_NUM*4-1:0]  m_be_bi,
  input  logic [MASTER_NUM*32-1:0] m_wdata_bi,
  output logic [MASTER_NUM-1:0]    m_ack_o,
  output logic [MASTER_NUM-1:0]    m_resp_o,
  output logic [31:0]              m_rdata_bo,
  output logic                     s_req_o,
  output logic                     s_we_o,
  output logic [31:0]              s_addr_bo,
  output logic [3:0]               s_be_bo,
  output logic [31:0]              s_wdata_bo,
  input  logic                     s_ack_i,
  input  logic                     s_resp_i,
  input  logic [31:0]              s_rdata_bi,
  output logic                     timeout_o
);

  localparam int PW = $clog2(MASTER_NUM);
  localparam int TW = $clog2(RESP_TIMEOUT);

  sfr_arb_state_t state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic [PW-1:0]  gnt;
  logic           gnt_vld;

  rr_pick #(.N(MASTER_NUM)) u_pick (
    .req_i   (m_req_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt),
    .valid_o (gnt_vld)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    timer_d    = timer_q;
    m_ack_o    = '0;
    m_resp_o   = '0;
    m_rdata_bo = '0;
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    timeout_o  = 1'b0;
    // Outputs are held quiet while reset is asserted so no handshake can
    // complete in a cycle whose state update is discarded.
    if (rst_i) begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            s_req_o = 1'b1;
            for (int k = 0; k < MASTER_NUM; k++) begin
              if (PW'(k) == gnt) begin
                s_we_o     = m_we_i[k];
                s_addr_bo  = m_addr_bi[32*k +: 32];
                s_be_bo    = m_be_bi[4*k +: 4];
                s_wdata_bo = m_wdata_bi[32*k +: 32];
                m_ack_o[k] = s_ack_i;
              end
            end
            if (s_ack_i) begin
              rr_ptr_d = (gnt == PW'(MASTER_NUM-1)) ? '0 : gnt + 1'b1;
              if (!s_we_o) begin
                owner_d = gnt;
                timer_d = '0;
                state_d = WAIT_RESP;
              end
            end
          end
        end
        WAIT_RESP: begin
          timer_d = timer_q + 1'b1;
          // A real response in the timeout cycle takes precedence.
          if (s_resp_i || timer_q == TW'(RESP_TIMEOUT-1)) begin
            for (int k = 0; k < MASTER_NUM; k++)
              if (PW'(k) == owner_q) m_resp_o[k] = 1'b1;
            m_rdata_bo = s_resp_i ? s_rdata_bi : SFR_ARB_ERR_RDATA;
            timeout_o  = !s_resp_i;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
    end
  end

endmodule
